time_of_day_counter: RTL and testbench

Free-running seconds/minutes/hours counter for the digital century clock, advanced by a 1 Hz enable tick.
It sits directly upstream of the 6-bit divide-by-10 / mod-10 digit splitters, which consume its sec/min fields, and of the date counter, which consumes its day_tick.
It also supports user time-setting through a set-mode write interface.
All fields are guaranteed in range (sec/min 0..59, hour 0..23), so downstream dividers never see values above 59.

---
 rtl/clock_pkg.sv | 23 ++
 rtl/time_of_day_counter_if.sv | 25 ++
 rtl/time_of_day_counter_wrap_counter.sv | 52 +++++
 rtl/time_of_day_counter.sv | 97 +++++++++
 tb/tb_time_of_day_counter.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/clock_pkg.sv
// Shared constants and helpers for the time-of-day, digit-split and date stages.
package clock_pkg;

  localparam int SEC_MAX_C  = 59;
  localparam int MIN_MAX_C  = 59;
  localparam int HOUR_MAX_C = 23;

  localparam int SEC_W  = 6;
  localparam int HOUR_W = 5;

  typedef enum logic [1:0] {
    SEL_SEC  = 2'd0,
    SEL_MIN  = 2'd1,
    SEL_HOUR = 2'd2,
    SEL_CLR  = 2'd3
  } set_sel_e;

  // Unsigned range check used for every field write, hour zero-extended by the caller.
  function automatic logic fits_field(input logic [SEC_W-1:0] val, input logic [SEC_W-1:0] max_v);
    return (val <= max_v);
  endfunction

endpackage

// File: rtl/time_of_day_counter_if.sv
// Tick, set-mode write and time/status outputs of the time-of-day counter.
interface time_of_day_counter_if;
  import clock_pkg::*;

  logic              tick_1hz;
  logic              set_en;
  logic              set_wr;
  logic [1:0]        set_sel;
  logic [SEC_W-1:0]  set_val;
  logic [SEC_W-1:0]  sec;
  logic [SEC_W-1:0]  min;
  logic [HOUR_W-1:0] hour;
  logic              day_tick;
  logic              set_err;

  modport master (
    output tick_1hz, set_en, set_wr, set_sel, set_val,
    input  sec, min, hour, day_tick, set_err
  );

  modport slave (
    input  tick_1hz, set_en, set_wr, set_sel, set_val,
    output sec, min, hour, day_tick, set_err
  );
endinterface

// File: rtl/time_of_day_counter_wrap_counter.sv
// Generic modulo counter: clear beats load beats increment; carry is combinational.
module wrap_counter #(
  parameter int W   = 6,
  parameter int MAX = 59
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         clr,
  output logic [W-1:0] value,
  output logic         carry
);

  localparam logic [W-1:0] MAX_V = W'(MAX);
  localparam logic [W-1:0] ONE_V = W'(1);

  logic [W-1:0] value_r;
  logic [W-1:0] next_s;

  // Next-value selection.
  always_comb begin
    next_s = value_r;
    if (clr) begin
      next_s = '0;
    end else if (load) begin
      next_s = load_val;
    end else if (inc) begin
      if (value_r == MAX_V) begin
        next_s = '0;
      end else begin
        next_s = value_r + ONE_V;
      end
    end else begin
      next_s = value_r;
    end
  end

  // Value register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value_r <= '0;
    end else begin
      value_r <= next_s;
    end
  end

  assign value = value_r;
  assign carry = inc & (value_r == MAX_V);

endmodule

// File: rtl/time_of_day_counter.sv
// Seconds/minutes/hours counter advanced by a 1 Hz tick, with range-checked set-mode writes.
module time_of_day_counter
  import clock_pkg::*;
#(
  parameter int SEC_MAX  = SEC_MAX_C,
  parameter int MIN_MAX  = MIN_MAX_C,
  parameter int HOUR_MAX = HOUR_MAX_C
) (
  input logic                 clk,
  input logic                 rst,
  time_of_day_counter_if.slave bus
);

  localparam logic [SEC_W-1:0] SEC_MAX_V  = SEC_W'(SEC_MAX);
  localparam logic [SEC_W-1:0] MIN_MAX_V  = SEC_W'(MIN_MAX);
  localparam logic [SEC_W-1:0] HOUR_MAX_V = SEC_W'(HOUR_MAX);

  logic              tick_run_s;
  logic              wr_s;
  logic              sec_load_s;
  logic              min_load_s;
  logic              hour_load_s;
  logic              clr_s;
  logic              reject_s;
  logic              sec_carry_s;
  logic              min_carry_s;
  logic              hour_carry_s;
  logic [SEC_W-1:0]  sec_s;
  logic [SEC_W-1:0]  min_s;
  logic [HOUR_W-1:0] hour_s;
  logic              day_tick_r;
  logic              set_err_r;

  // Set-mode decode and range checks; ticks only count outside set mode.
  always_comb begin
    tick_run_s  = bus.tick_1hz & ~bus.set_en;
    wr_s        = bus.set_en & bus.set_wr;
    sec_load_s  = 1'b0;
    min_load_s  = 1'b0;
    hour_load_s = 1'b0;
    clr_s       = 1'b0;
    reject_s    = 1'b0;
    if (wr_s) begin
      case (set_sel_e'(bus.set_sel))
        SEL_SEC: begin
          if (fits_field(bus.set_val, SEC_MAX_V)) sec_load_s = 1'b1;
          else reject_s = 1'b1;
        end
        SEL_MIN: begin
          if (fits_field(bus.set_val, MIN_MAX_V)) min_load_s = 1'b1;
          else reject_s = 1'b1;
        end
        SEL_HOUR: begin
          if (fits_field(bus.set_val, HOUR_MAX_V)) hour_load_s = 1'b1;
          else reject_s = 1'b1;
        end
        SEL_CLR: clr_s = 1'b1;
        default: reject_s = 1'b0;
      endcase
    end else begin
      reject_s = 1'b0;
    end
  end

  wrap_counter #(.W(SEC_W), .MAX(SEC_MAX)) u_sec (
    .clk(clk), .rst(rst), .inc(tick_run_s), .load(sec_load_s),
    .load_val(bus.set_val), .clr(clr_s), .value(sec_s), .carry(sec_carry_s)
  );

  wrap_counter #(.W(SEC_W), .MAX(MIN_MAX)) u_min (
    .clk(clk), .rst(rst), .inc(sec_carry_s), .load(min_load_s),
    .load_val(bus.set_val), .clr(clr_s), .value(min_s), .carry(min_carry_s)
  );

  wrap_counter #(.W(HOUR_W), .MAX(HOUR_MAX)) u_hour (
    .clk(clk), .rst(rst), .inc(min_carry_s), .load(hour_load_s),
    .load_val(bus.set_val[HOUR_W-1:0]), .clr(clr_s), .value(hour_s), .carry(hour_carry_s)
  );

  // Status pulses: hour carry only happens on a counting tick, so writes never raise day_tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      day_tick_r <= 1'b0;
      set_err_r  <= 1'b0;
    end else begin
      day_tick_r <= hour_carry_s;
      set_err_r  <= reject_s;
    end
  end

  assign bus.sec      = sec_s;
  assign bus.min      = min_s;
  assign bus.hour     = hour_s;
  assign bus.day_tick = day_tick_r;
  assign bus.set_err  = set_err_r;

endmodule

// File: tb/tb_time_of_day_counter.sv
// Self-checking bench: directed scenarios plus random stimulus against a seconds-of-day model.
module tb_time_of_day_counter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  // Reference model: time kept as seconds since midnight.
  int tod = 0;
  bit exp_dt = 1'b0;
  bit exp_err = 1'b0;

  time_of_day_counter_if bus();

  time_of_day_counter dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  function automatic logic [18:0] observed();
    return {bus.hour, bus.min, bus.sec, bus.day_tick, bus.set_err};
  endfunction

  function automatic logic [18:0] expected();
    logic [4:0] h;
    logic [5:0] m;
    logic [5:0] s;
    h = 5'(tod / 3600);
    m = 6'((tod / 60) % 60);
    s = 6'(tod % 60);
    return {h, m, s, exp_dt, exp_err};
  endfunction

  task automatic step(input bit tick, input bit en, input bit wr, input bit [1:0] sel, input bit [5:0] val);
    int v;
    bus.tick_1hz = tick;
    bus.set_en   = en;
    bus.set_wr   = wr;
    bus.set_sel  = sel;
    bus.set_val  = val;
    @(posedge clk);
    #1;
    v = int'(val);
    exp_dt  = 1'b0;
    exp_err = 1'b0;
    if (!en) begin
      if (tick) begin
        tod = (tod + 1) % 86400;
        exp_dt = (tod == 0);
      end
    end else if (wr) begin
      case (sel)
        2'd0: if (v <= 59) tod = tod - (tod % 60) + v; else exp_err = 1'b1;
        2'd1: if (v <= 59) tod = (tod / 3600) * 3600 + v * 60 + (tod % 60); else exp_err = 1'b1;
        2'd2: if (v <= 23) tod = v * 3600 + (tod % 3600); else exp_err = 1'b1;
        default: tod = 0;
      endcase
    end
    bus.tick_1hz = 1'b0;
    bus.set_wr   = 1'b0;
  endtask

  task automatic set_time(input bit [5:0] h, input bit [5:0] m, input bit [5:0] s);
    step(1'b0, 1'b1, 1'b1, 2'd2, h);
    step(1'b0, 1'b1, 1'b1, 2'd1, m);
    step(1'b0, 1'b1, 1'b1, 2'd0, s);
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (observed() !== 19'd0) begin
      failures++;
      $display("FAIL reset_state: got=%h required=%h", observed(), 19'd0);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset_mid_count();
    set_time(6'd12, 6'd34, 6'd56);
    step(1'b0, 1'b0, 1'b0, 2'd0, 6'd0);
    checks++;
    if (observed() !== expected()) begin
      failures++;
      $display("FAIL preset_12_34_56: got=%h required=%h", observed(), expected());
    end
    #2 rst = 1'b1;
    #1;
    tod = 0; exp_dt = 1'b0; exp_err = 1'b0;
    checks++;
    if (observed() !== 19'd0) begin
      failures++;
      $display("FAIL async_reset: got=%h required=%h", observed(), 19'd0);
    end
    #1 rst = 1'b0;
    step(1'b1, 1'b0, 1'b0, 2'd0, 6'd0);
    checks++;
    if (observed() !== {5'd0, 6'd0, 6'd1, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL first_tick_after_reset: got=%h required=%h", observed(), {5'd0, 6'd0, 6'd1, 1'b0, 1'b0});
    end
  endtask

  task automatic test_rollover();
    set_time(6'd23, 6'd59, 6'd58);
    step(1'b1, 1'b0, 1'b0, 2'd0, 6'd0);
    checks++;
    if (observed() !== {5'd23, 6'd59, 6'd59, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL rollover_tick1: got=%h required=%h", observed(), {5'd23, 6'd59, 6'd59, 1'b0, 1'b0});
    end
    step(1'b1, 1'b0, 1'b0, 2'd0, 6'd0);
    checks++;
    if (observed() !== {5'd0, 6'd0, 6'd0, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL rollover_tick2: got=%h required=%h", observed(), {5'd0, 6'd0, 6'd0, 1'b1, 1'b0});
    end
    step(1'b0, 1'b0, 1'b0, 2'd0, 6'd0);
    checks++;
    if (observed() !== {5'd0, 6'd0, 6'd0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL day_tick_one_clk: got=%h required=%h", observed(), {5'd0, 6'd0, 6'd0, 1'b0, 1'b0});
    end
  endtask

  task automatic test_carry();
    set_time(6'd9, 6'd59, 6'd59);
    step(1'b1, 1'b0, 1'b0, 2'd0, 6'd0);
    checks++;
    if (observed() !== {5'd10, 6'd0, 6'd0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL min_hour_carry: got=%h required=%h", observed(), {5'd10, 6'd0, 6'd0, 1'b0, 1'b0});
    end
  endtask

  task automatic test_range_reject();
    set_time(6'd4, 6'd5, 6'd6);
    step(1'b0, 1'b1, 1'b1, 2'd1, 6'd60);
    checks++;
    if (observed() !== {5'd4, 6'd5, 6'd6, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL reject_min_60: got=%h required=%h", observed(), {5'd4, 6'd5, 6'd6, 1'b0, 1'b1});
    end
    step(1'b0, 1'b1, 1'b1, 2'd2, 6'd24);
    checks++;
    if (observed() !== {5'd4, 6'd5, 6'd6, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL reject_hour_24: got=%h required=%h", observed(), {5'd4, 6'd5, 6'd6, 1'b0, 1'b1});
    end
    step(1'b0, 1'b1, 1'b1, 2'd2, 6'd23);
    checks++;
    if (observed() !== {5'd23, 6'd5, 6'd6, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL accept_hour_23: got=%h required=%h", observed(), {5'd23, 6'd5, 6'd6, 1'b0, 1'b0});
    end
    step(1'b0, 1'b1, 1'b1, 2'd0, 6'd63);
    checks++;
    if (observed() !== {5'd23, 6'd5, 6'd6, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL reject_sec_63: got=%h required=%h", observed(), {5'd23, 6'd5, 6'd6, 1'b0, 1'b1});
    end
    step(1'b0, 1'b1, 1'b0, 2'd0, 6'd0);
    checks++;
    if (observed() !== {5'd23, 6'd5, 6'd6, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL set_err_one_clk: got=%h required=%h", observed(), {5'd23, 6'd5, 6'd6, 1'b0, 1'b0});
    end
  endtask

  task automatic test_freeze();
    set_time(6'd5, 6'd6, 6'd7);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b1, 1'b0, 2'd0, 6'd0);
      checks++;
      if (observed() !== {5'd5, 6'd6, 6'd7, 1'b0, 1'b0}) begin
        failures++;
        $display("FAIL freeze_tick%0d: got=%h required=%h", i, observed(), {5'd5, 6'd6, 6'd7, 1'b0, 1'b0});
      end
    end
    step(1'b1, 1'b0, 1'b0, 2'd0, 6'd0);
    checks++;
    if (observed() !== {5'd5, 6'd6, 6'd8, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL resume_no_catchup: got=%h required=%h", observed(), {5'd5, 6'd6, 6'd8, 1'b0, 1'b0});
    end
  endtask

  task automatic test_ignored_clear();
    set_time(6'd7, 6'd8, 6'd9);
    step(1'b0, 1'b0, 1'b1, 2'd0, 6'd30);
    checks++;
    if (observed() !== {5'd7, 6'd8, 6'd9, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL write_outside_set: got=%h required=%h", observed(), {5'd7, 6'd8, 6'd9, 1'b0, 1'b0});
    end
    step(1'b0, 1'b1, 1'b1, 2'd3, 6'd17);
    checks++;
    if (observed() !== {5'd0, 6'd0, 6'd0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL clear_all: got=%h required=%h", observed(), {5'd0, 6'd0, 6'd0, 1'b0, 1'b0});
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      bit en;
      bit tick;
      bit wr;
      bit [1:0] sel;
      bit [5:0] val;
      en   = ($urandom_range(3) == 0);
      tick = ($urandom_range(3) != 0);
      wr   = ($urandom_range(2) == 0);
      sel  = 2'($urandom_range(3));
      val  = 6'($urandom_range(63));
      if (i % 100 == 0) set_time(6'd23, 6'd59, 6'(50 + $urandom_range(9)));
      step(tick, en, wr, sel, val);
      checks++;
      if (observed() !== expected()) begin
        failures++;
        $display("FAIL random_step%0d: got=%h required=%h", i, observed(), expected());
      end
    end
  endtask

  initial begin
    bus.tick_1hz = 1'b0;
    bus.set_en   = 1'b0;
    bus.set_wr   = 1'b0;
    bus.set_sel  = 2'd0;
    bus.set_val  = 6'd0;
    test_reset();
    test_reset_mid_count();
    test_rollover();
    test_carry();
    test_range_reject();
    test_freeze();
    test_ignored_clear();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
